// File: rtl/pair_scan_pkg.sv
// Shared types and constants for the pair-scan scheduler.
//   state_t         : scheduler FSM states
//   PATTERN_DEFAULT : nibble code whose back-to-back occurrence is a hit
package pair_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [3:0] PATTERN_DEFAULT = 4'b1101;

endpackage

// File: rtl/pair_det.sv
// Consecutive-pattern nibble pair detector, the resource shared by all channels.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   clr   : clears the "previous nibble matched" flag (start of a frame)
//   acc   : a nibble is being accepted this cycle
//   nib   : the nibble being accepted
//   hit   : combinational; accepted nibble matches and so did the previous one
module pair_det
    import pair_scan_pkg::*;
#(
    parameter logic [3:0] PATTERN = PATTERN_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       acc,
    input  logic [3:0] nib,
    output logic       hit
);

    logic prev_match_q;
    logic prev_match_d;
    logic is_pat;

    // The flag only moves on an accept, so idle cycles inside a frame do not
    // break a run of matching nibbles.
    always_comb begin
        is_pat       = (nib == PATTERN);
        hit          = acc & is_pat & prev_match_q;
        prev_match_d = prev_match_q;
        if (clr) begin
            prev_match_d = 1'b0;
        end else if (acc) begin
            prev_match_d = is_pat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_match_q <= 1'b0;
        end else begin
            prev_match_q <= prev_match_d;
        end
    end

endmodule

// File: rtl/pair_scan_sched.sv
// Round-robin scheduler sharing one pair detector among NCH nibble sources.
//   clk, reset : clock (rising edge) and asynchronous active-low reset
//   req        : per-channel frame request, held until that channel is done
//   len        : per-channel frame length in nibbles, LEN_W bits per channel
//   in_valid   : per-channel nibble valid
//   in_data    : per-channel nibble, 4 bits per channel
//   in_ready   : per-channel accept, only the granted channel while running
//   gnt        : registered one-hot grant
//   done       : one-cycle pulse when a frame completes
//   aborted    : with done, 1 when the frame ended because req dropped
//   done_id    : channel of the last completed frame (held)
//   hit_cnt    : saturating hit count of the last completed frame (held)
module pair_scan_sched
    import pair_scan_pkg::*;
#(
    parameter int         NCH     = 4,
    parameter logic [3:0] PATTERN = PATTERN_DEFAULT,
    parameter int         LEN_W   = 8,
    parameter int         CNT_W   = 8,
    localparam int        ID_W    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*LEN_W-1:0] len,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*4-1:0]     in_data,
    output logic [NCH-1:0]       in_ready,
    output logic [NCH-1:0]       gnt,
    output logic                 done,
    output logic                 aborted,
    output logic [ID_W-1:0]      done_id,
    output logic [CNT_W-1:0]     hit_cnt
);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   g_q, g_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0]    gnt_q, gnt_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;

    logic [LEN_W-1:0]  len_arr [NCH];
    logic [3:0]        nib_arr [NCH];
    logic [ID_W-1:0]   winner;
    logic [NCH-1:0]    g_onehot;
    logic              det_clr;
    logic              det_acc;
    logic              det_hit;
    logic              last_acc;
    logic              req_drop;

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign len_arr[i] = len[i*LEN_W +: LEN_W];
        assign nib_arr[i] = in_data[i*4 +: 4];
    end

    // First set request at or after the pointer, walking upward with wrap.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NCH-1:0] r,
                                                 input logic [ID_W-1:0] p);
        logic [ID_W-1:0] w;
        logic [ID_W-1:0] c;
        logic            found;
        w     = p;
        c     = p;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && r[c]) begin
                w     = c;
                found = 1'b1;
            end
            c = (c == ID_W'(NCH - 1)) ? '0 : c + ID_W'(1);
        end
        return w;
    endfunction

    assign winner   = rr_pick(req, ptr_q);
    assign g_onehot = NCH'(1) << g_q;

    // A completing accept wins over a simultaneous req drop: the frame is whole.
    assign last_acc = det_acc && ((acc_cnt_q + LEN_W'(1)) == len_q);
    assign req_drop = (state_q == RUN) && !req[g_q] && !last_acc;

    pair_det #(
        .PATTERN (PATTERN)
    ) u_det (
        .clk   (clk),
        .reset (reset),
        .clr   (det_clr),
        .acc   (det_acc),
        .nib   (nib_arr[g_q]),
        .hit   (det_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = GRANT;
            GRANT:   state_d = (len_q == '0) ? REPORT : RUN;
            RUN:     if (last_acc || req_drop) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only the granted channel sees ready, and only while the frame runs.
    always_comb begin
        in_ready = '0;
        det_clr  = 1'b0;
        det_acc  = 1'b0;
        case (state_q)
            GRANT: det_clr = 1'b1;
            RUN: begin
                in_ready = g_onehot;
                det_acc  = in_valid[g_q];
            end
            default: ;
        endcase
    end

    // Result registers load from cnt_d so a hit on the final nibble is included.
    always_comb begin
        ptr_d     = ptr_q;
        g_d       = g_q;
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q;
        cnt_d     = cnt_q;
        done_id_d = done_id_q;
        hit_cnt_d = hit_cnt_q;
        if ((state_q == IDLE) && (|req)) begin
            g_d   = winner;
            len_d = len_arr[winner];
        end
        if (state_q == GRANT) begin
            acc_cnt_d = '0;
            cnt_d     = '0;
        end
        if (det_acc) begin
            acc_cnt_d = acc_cnt_q + LEN_W'(1);
            if (det_hit && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (state_q == REPORT) begin
            ptr_d = (g_q == ID_W'(NCH - 1)) ? '0 : g_q + ID_W'(1);
        end
        gnt_d     = (state_d == RUN) ? g_onehot : '0;
        done_d    = (state_d == REPORT);
        aborted_d = (state_d == REPORT) && req_drop;
        if (state_d == REPORT) begin
            done_id_d = g_q;
            hit_cnt_d = cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q     <= '0;
            g_q       <= '0;
            len_q     <= '0;
            acc_cnt_q <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            done_id_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            g_q       <= g_d;
            len_q     <= len_d;
            acc_cnt_q <= acc_cnt_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            done_id_q <= done_id_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign done_id = done_id_q;
    assign hit_cnt = hit_cnt_q;

endmodule
